// File: rtl/heichips25_nibble_mem_bridge.sv
// Bridges a 4-bit nibble request/response stream onto a 32-bit word memory port.
// Writes gather eight LSB-first nibbles; reads stream the word back MSB-first.
module heichips25_nibble_mem_bridge (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req_nibble_i,
   input  logic [7:0]  req_addr_i,
   input  logic        req_write_i,
   input  logic        req_strb_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   output logic [3:0]  rsp_nibble_o,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic        rsp_last_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [7:0]  mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o
);

   typedef enum logic [2:0] {
      StIdle,
      StWrCollect,
      StMemReq,
      StMemWait,
      StRspSend,
      StRspCommit
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  addr_q, addr_d;
   logic        we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [7:0]  nstrb_q, nstrb_d;
   logic [31:0] rdata_q, rdata_d;
   logic        beat;

   assign beat = req_valid_i & req_ready_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:      if (beat) state_d = req_write_i ? StWrCollect : StMemReq;
         StWrCollect: if (beat && (cnt_q == 3'd7)) state_d = StMemReq;
         StMemReq:    if (mem_gnt_i) state_d = we_q ? StIdle : StMemWait;
         StMemWait:   if (mem_rvalid_i) state_d = StRspSend;
         StRspSend:   if (rsp_ready_i && (cnt_q == 3'd7)) state_d = StRspCommit;
         StRspCommit: state_d = StIdle;
         default:     state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready_o  = 1'b0;
      busy_o       = 1'b1;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = 8'h00;
      mem_wdata_o  = 32'h0;
      mem_be_o     = 4'h0;
      rsp_valid_o  = 1'b0;
      rsp_last_o   = 1'b0;
      rsp_nibble_o = 4'h0;
      unique case (state_q)
         StIdle: begin
            req_ready_o = 1'b1;
            busy_o      = 1'b0;
         end
         StWrCollect: req_ready_o = 1'b1;
         StMemReq: begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
            mem_be_o    = {nstrb_q[7] | nstrb_q[6], nstrb_q[5] | nstrb_q[4],
                           nstrb_q[3] | nstrb_q[2], nstrb_q[1] | nstrb_q[0]};
         end
         StRspSend: begin
            rsp_valid_o  = 1'b1;
            // ~cnt_q == 7 - cnt_q, giving MSB-first nibble order
            rsp_nibble_o = rdata_q[{~cnt_q, 2'b00} +: 4];
            rsp_last_o   = (cnt_q == 3'd7);
         end
         StRspCommit: rsp_valid_o = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      nstrb_d = nstrb_q;
      rdata_d = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (beat) begin
               addr_d = req_addr_i;
               we_d   = req_write_i;
               if (req_write_i) begin
                  wdata_d = {28'h0, req_nibble_i};
                  nstrb_d = {7'h0, req_strb_i};
                  cnt_d   = 3'd1;
               end else begin
                  wdata_d = 32'h0;
                  nstrb_d = 8'h00;
                  cnt_d   = 3'd0;
               end
            end
         end
         StWrCollect: begin
            if (beat) begin
               wdata_d[{cnt_q, 2'b00} +: 4] = req_nibble_i;
               nstrb_d[cnt_q]               = req_strb_i;
               cnt_d                        = cnt_q + 3'd1;
            end
         end
         StMemWait: begin
            if (mem_rvalid_i) begin
               rdata_d = mem_rdata_i;
               cnt_d   = 3'd0;
            end
         end
         StRspSend: if (rsp_ready_i) cnt_d = cnt_q + 3'd1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 3'd0;
         addr_q  <= 8'h00;
         we_q    <= 1'b0;
         wdata_q <= 32'h0;
         nstrb_q <= 8'h00;
         rdata_q <= 32'h0;
      end else begin
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         nstrb_q <= nstrb_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_heichips25_nibble_mem_bridge.sv
// Scoreboard bench: requests push expected memory transactions and response nibbles,
// independent monitors pop and compare whatever the bridge presents.
module tb_heichips25_nibble_mem_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_nibble_i;
   logic [7:0]  req_addr_i;
   logic        req_write_i, req_strb_i, req_valid_i, req_ready_o;
   logic [3:0]  rsp_nibble_o;
   logic        rsp_valid_o, rsp_ready_i, rsp_last_o;
   logic        mem_req_o, mem_we_o;
   logic [7:0]  mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        busy_o;

   heichips25_nibble_mem_bridge dut (
      .clk(clk), .rst_n(rst_n),
      .req_nibble_i(req_nibble_i), .req_addr_i(req_addr_i), .req_write_i(req_write_i),
      .req_strb_i(req_strb_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .rsp_nibble_o(rsp_nibble_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_last_o(rsp_last_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mem_tx_t;

   typedef struct packed {
      logic [3:0] nib;
      logic       last;
      logic       commit;
   } rsp_t;

   mem_tx_t     mem_q[$];
   rsp_t        rsp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] ram[256];
   logic [31:0] ref_mem[256];

   // memory responder / sink controls
   bit          rnd_mem = 1'b0;
   int          gnt_fix = 0, rv_fix = 0, gnt_dly = 0, rv_dly = 0;
   bit          rd_pend = 1'b0;
   logic [31:0] rd_data;
   bit          rdy_rand = 1'b0;
   int          stall_left = 0;
   bit          prev_commit = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic note_fail(input string name);
      n_cmp++;
      n_err++;
      if (n_err <= 30) $display("FAIL %s at %0t", name, $time);
   endtask

   // memory monitor
   always @(negedge clk) begin
      mem_tx_t e;
      if (rst_n) begin
         if (mem_req_o) begin
            check("busy_in_memreq", busy_o, 1);
            check("ready_low_memreq", req_ready_o, 0);
            if (mem_q.size() == 0) note_fail("unexpected_mem_req");
            else begin
               e = mem_q[0];
               check("mem_we", mem_we_o, e.we);
               check("mem_addr", mem_addr_o, e.addr);
               if (e.we) begin
                  check("mem_wdata", mem_wdata_o, e.wdata);
                  check("mem_be", mem_be_o, e.be);
               end
               if (mem_gnt_i) void'(mem_q.pop_front());
            end
         end else begin
            check("mem_idle_zero", {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, 0);
         end
      end
   end

   // response monitor
   always @(negedge clk) begin
      rsp_t e;
      bit   was_commit;
      was_commit = 1'b0;
      if (rst_n) begin
         if (prev_commit) check("valid_gap_after_commit", rsp_valid_o, 0);
         if (rsp_valid_o) begin
            check("ready_low_rsp", req_ready_o, 0);
            check("busy_in_rsp", busy_o, 1);
            if (rsp_q.size() == 0) note_fail("unexpected_rsp_valid");
            else begin
               e = rsp_q[0];
               check("rsp_nibble", rsp_nibble_o, e.nib);
               check("rsp_last", rsp_last_o, e.last);
               if (e.commit || rsp_ready_i) begin
                  void'(rsp_q.pop_front());
                  was_commit = e.commit;
               end
            end
         end else begin
            check("rsp_idle_zero", {rsp_nibble_o, rsp_last_o}, 0);
         end
      end
      prev_commit = was_commit;
   end

   // memory model: grants after a delay, returns read data later, sprays stray rvalids
   initial begin
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         if (rd_pend) begin
            if (rv_dly == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = rd_data;
               rd_pend      = 1'b0;
            end else rv_dly--;
         end else if ($urandom_range(0, 5) == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = $urandom;
         end
         if (mem_req_o) begin
            if (gnt_dly == 0) begin
               mem_gnt_i = 1'b1;
               gnt_dly   = rnd_mem ? $urandom_range(0, 4) : gnt_fix;
               if (mem_we_o) begin
                  for (int b = 0; b < 4; b++)
                     if (mem_be_o[b]) ram[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
               end else begin
                  rd_pend = 1'b1;
                  rd_data = ram[mem_addr_o];
                  rv_dly  = rnd_mem ? $urandom_range(0, 3) : rv_fix;
               end
            end else gnt_dly--;
         end
      end
   end

   // response sink
   initial begin
      rsp_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_rand) rsp_ready_i = ($urandom_range(0, 2) != 0);
         else if (stall_left > 0 && rsp_valid_o && rsp_nibble_o == 4'h4 && !rsp_last_o) begin
            rsp_ready_i = 1'b0;
            stall_left--;
         end else rsp_ready_i = 1'b1;
      end
   end

   // called at posedge+1; returns at posedge+1 after the beat transferred, valid left high
   task automatic beat(input logic [3:0] nib, input logic [7:0] addr, input logic we,
                       input logic strb);
      int t;
      t = 0;
      req_nibble_i = nib;
      req_addr_i   = addr;
      req_write_i  = we;
      req_strb_i   = strb;
      req_valid_i  = 1'b1;
      forever begin
         @(negedge clk);
         if (req_ready_o) break;
         t++;
         if (t > 500) begin
            note_fail("req_ready_timeout");
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [7:0] strb, input bit keep);
      mem_tx_t e;
      e.we    = 1'b1;
      e.addr  = addr;
      e.wdata = data;
      for (int b = 0; b < 4; b++) e.be[b] = strb[2*b] | strb[2*b+1];
      for (int b = 0; b < 4; b++)
         if (e.be[b]) ref_mem[addr][8*b +: 8] = data[8*b +: 8];
      mem_q.push_back(e);
      for (int i = 0; i < 8; i++) beat(data[4*i +: 4], addr, 1'b1, strb[i]);
      if (!keep) req_valid_i = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] addr, input bit keep);
      mem_tx_t     e;
      rsp_t        r;
      logic [31:0] w;
      e = '{we: 1'b0, addr: addr, wdata: 32'h0, be: 4'h0};
      mem_q.push_back(e);
      w = ref_mem[addr];
      for (int i = 0; i < 8; i++) begin
         r.nib    = w[28-4*i +: 4];
         r.last   = (i == 7);
         r.commit = 1'b0;
         rsp_q.push_back(r);
      end
      r = '{nib: 4'h0, last: 1'b0, commit: 1'b1};
      rsp_q.push_back(r);
      beat(4'($urandom), addr, 1'b0, 1'($urandom));
      if (!keep) req_valid_i = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      req_valid_i = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_q.size() == 0 && rsp_q.size() == 0 && !busy_o) break;
         t++;
         if (t > 2000) begin
            note_fail("drain_timeout");
            mem_q.delete();
            rsp_q.delete();
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs();
      check("rst_req_ready", req_ready_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_mem_req", mem_req_o, 0);
      check("rst_rsp_valid", {rsp_valid_o, rsp_last_o, rsp_nibble_o}, 0);
      check("rst_mem_fields", {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, 0);
   endtask

   initial begin
      rst_n        = 1'b0;
      req_nibble_i = 4'h0;
      req_addr_i   = 8'h00;
      req_write_i  = 1'b0;
      req_strb_i   = 1'b0;
      req_valid_i  = 1'b0;
      for (int i = 0; i < 256; i++) begin
         ram[i]     = $urandom;
         ref_mem[i] = ram[i];
      end
      ram[8'h34] = 32'h12345678; ref_mem[8'h34] = 32'h12345678;
      ram[8'h00] = 32'hCAFEF00D; ref_mem[8'h00] = 32'hCAFEF00D;

      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // full-word write, granted immediately
      do_write(8'h12, 32'hDEADBEEF, 8'hFF, 1'b0);
      // only nibbles 2 and 3 strobed
      do_write(8'h05, 32'h0000AB00, 8'b0000_1100, 1'b0);
      wait_drain();

      // read with a slow grant and delayed rvalid
      gnt_fix = 5; gnt_dly = 5; rv_fix = 1;
      do_read(8'h34, 1'b0);
      wait_drain();

      // same read with a stall while nibble 4 is shown
      gnt_fix = 0; gnt_dly = 0; rv_fix = 0;
      stall_left = 3;
      do_read(8'h34, 1'b0);
      wait_drain();
      check("stall_consumed", stall_left, 0);

      // reset in the middle of a write collection
      for (int i = 0; i < 3; i++) beat(4'(i + 1), 8'h00, 1'b1, 1'b1);
      req_valid_i = 1'b0;
      rst_n = 1'b0;
      #2;
      check_reset_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_read(8'h00, 1'b0);
      wait_drain();

      // req_valid_i held high across read wait and response stream
      do_read(8'h34, 1'b1);
      do_write(8'h34, 32'h0BADF00D, 8'b1111_0011, 1'b1);
      do_read(8'h34, 1'b1);
      do_read(8'h12, 1'b0);
      wait_drain();

      // randomized traffic over a small address window
      rnd_mem  = 1'b1;
      rdy_rand = 1'b1;
      for (int n = 0; n < 80; n++) begin
         logic [7:0] a;
         a = 8'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 8'($urandom), 1'($urandom));
         else do_read(a, 1'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            req_valid_i = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
